// File: rtl/ren_delay_ctrl_if.sv
// Handshake bundle between a delay-line sequencer and its neighbours.
// slave: the sequencer side; master: the upstream/downstream/line side.
interface ren_delay_ctrl_if #(
    parameter int P_WIDTH = 8
);
    logic               i_s_valid;
    logic               o_s_ready;
    logic               o_dl_en;
    logic [P_WIDTH-1:0] i_dl_data;
    logic               o_m_valid;
    logic               i_m_ready;
    logic [P_WIDTH-1:0] o_m_data;

    modport slave (
        input  i_s_valid, i_dl_data, i_m_ready,
        output o_s_ready, o_dl_en, o_m_valid, o_m_data
    );

    modport master (
        output i_s_valid, i_dl_data, i_m_ready,
        input  o_s_ready, o_dl_en, o_m_valid, o_m_data
    );
endinterface

// File: rtl/ren_delay_ctrl.sv
// Valid/ready sequencer for an external enable-gated delay line.
// Tracks a valid bit per line stage, gates the line enable while the line
// is empty, and catches line output in a show-ahead FIFO. Input is admitted
// only against a free FIFO credit, so the line never has to stall.
module ren_delay_ctrl #(
    parameter int P_WIDTH      = 8,
    parameter int P_NUM_DELAY  = 8,
    parameter int P_FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_flush,
    ren_delay_ctrl_if.slave bus
);
    localparam int PW = $clog2(P_FIFO_DEPTH);
    localparam int CW = $clog2(P_FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(P_FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(P_FIFO_DEPTH);

    // cnt_q counts items in the line plus items in the FIFO (credits in use)
    logic [CW-1:0]                         cnt_q, cnt_d;
    logic [CW-1:0]                         fill_q, fill_d;
    logic [P_NUM_DELAY-1:0]                vld_q, vld_d;
    logic [PW-1:0]                         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                         rd_ptr_q, rd_ptr_d;
    logic [P_FIFO_DEPTH-1:0][P_WIDTH-1:0]  mem_q;

    logic s_fire, m_fire, dl_en, fifo_wr, fifo_empty, fifo_full;

    // Pointer wrap handles non-power-of-two depths
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty    = (fill_q == '0);
    assign fifo_full     = (fill_q == FULL_CNT);
    assign bus.o_s_ready = (cnt_q < FULL_CNT) & ~i_flush;
    assign s_fire        = bus.i_s_valid & bus.o_s_ready;
    assign bus.o_m_valid = ~fifo_empty & ~i_flush;
    assign m_fire        = bus.o_m_valid & bus.i_m_ready;
    // Line only advances while it holds data or takes a new item; frozen in flush
    assign dl_en         = ~i_flush & (s_fire | (|vld_q));
    assign bus.o_dl_en   = dl_en;
    assign fifo_wr       = dl_en & vld_q[P_NUM_DELAY-1];
    assign bus.o_m_data  = mem_q[rd_ptr_q];

    // Next-state for credits, FIFO occupancy/pointers and stage valids
    always_comb begin
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;

        if (s_fire && !m_fire)      cnt_d = cnt_q + CW'(1);
        else if (!s_fire && m_fire) cnt_d = cnt_q - CW'(1);

        if (fifo_wr && !m_fire)      fill_d = fill_q + CW'(1);
        else if (!fifo_wr && m_fire) fill_d = fill_q - CW'(1);

        if (fifo_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (m_fire)  rd_ptr_d = ptr_inc(rd_ptr_q);

        if (dl_en) begin
            vld_d[0] = s_fire;
            for (int i = 1; i < P_NUM_DELAY; i++) vld_d[i] = vld_q[i-1];
        end

        // Stale line contents are harmless once vld is cleared
        if (i_flush) begin
            cnt_d    = '0;
            fill_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            vld_d    = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '0;
        else if (fifo_wr) mem_q[wr_ptr_q] <= bus.i_dl_data;
    end

    // Credits must make a write into a full FIFO impossible
    a_no_wr_full: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr && fifo_full));
endmodule

// File: tb/tb_ren_delay_ctrl.sv
// Directed bench: DUT A (N=4, depth 8) and DUT B (N=1, depth 2), each
// driving a behavioural enable-gated delay line.
module tb_ren_delay_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flA = 1'b0, flB = 1'b0;
    logic [7:0] sdA = '0, sdB = '0;
    logic [3:0][7:0] lineA;
    logic [7:0] lineB;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ren_delay_ctrl_if #(.P_WIDTH(8)) ifA ();
    ren_delay_ctrl_if #(.P_WIDTH(8)) ifB ();

    ren_delay_ctrl #(.P_WIDTH(8), .P_NUM_DELAY(4), .P_FIFO_DEPTH(8)) dutA (
        .clk(clk), .rst_n(rst_n), .i_flush(flA), .bus(ifA.slave));
    ren_delay_ctrl #(.P_WIDTH(8), .P_NUM_DELAY(1), .P_FIFO_DEPTH(2)) dutB (
        .clk(clk), .rst_n(rst_n), .i_flush(flB), .bus(ifB.slave));

    // Enable-gated delay lines
    always_ff @(posedge clk) if (ifA.o_dl_en) lineA <= {lineA[2:0], sdA};
    always_ff @(posedge clk) if (ifB.o_dl_en) lineB <= sdB;
    assign ifA.i_dl_data = lineA[3];
    assign ifB.i_dl_data = lineB;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       fl;
        logic       er;
        logic       ee;
        logic       emv;
        logic [7:0] emd;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            ifA.i_s_valid = tbl[i].sv; sdA = tbl[i].sd;
            ifA.i_m_ready = tbl[i].mr; flA = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("%s[%0d].s_ready", tag, i), ifA.o_s_ready, tbl[i].er);
            chk($sformatf("%s[%0d].dl_en", tag, i), ifA.o_dl_en, tbl[i].ee);
            chk($sformatf("%s[%0d].m_valid", tag, i), ifA.o_m_valid, tbl[i].emv);
            if (tbl[i].emv) chk($sformatf("%s[%0d].m_data", tag, i), ifA.o_m_data, tbl[i].emd);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int acc, nsent, ngot;
        ifA.i_s_valid = 0; ifA.i_m_ready = 0;
        ifB.i_s_valid = 0; ifB.i_m_ready = 0;

        // Single item 0xA5 in cycle 0: enable cycles 0..4, output cycle 5
        for (int i = 0; i < 8; i++) begin
            tbl[i].sv = (i == 0); tbl[i].sd = (i == 0) ? 8'hA5 : 8'h00;
            tbl[i].mr = 1'b1; tbl[i].fl = 1'b0; tbl[i].er = 1'b1;
            tbl[i].ee = (i <= 4); tbl[i].emv = (i == 5); tbl[i].emd = 8'hA5;
        end

        // Reset state
        @(negedge clk);
        chk("rst.s_ready", ifA.o_s_ready, 1);
        chk("rst.dl_en", ifA.o_dl_en, 0);
        chk("rst.m_valid", ifA.o_m_valid, 0);
        chk("rst.m_data", ifA.o_m_data, 0);
        chk("rstB.m_valid", ifB.o_m_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_table("single");

        // Stream of 20 back-to-back items
        for (int t = 0; t < 26; t++) begin
            @(posedge clk); #1;
            ifA.i_s_valid = (t < 20); sdA = 8'(t); ifA.i_m_ready = 1;
            @(negedge clk);
            if (t < 20) chk($sformatf("stream[%0d].s_ready", t), ifA.o_s_ready, 1);
            chk($sformatf("stream[%0d].m_valid", t), ifA.o_m_valid, (t >= 5 && t < 25));
            if (t >= 5 && t < 25) chk($sformatf("stream[%0d].m_data", t), ifA.o_m_data, t - 5);
        end

        // Backpressure: exactly 8 credits
        acc = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            ifA.i_s_valid = 1; sdA = 8'(8'h40 + acc); ifA.i_m_ready = 0;
            @(negedge clk);
            if (ifA.o_s_ready) acc++;
            if (t == 8) chk("bp.s_ready_low", ifA.o_s_ready, 0);
            if (t == 19) begin
                chk("bp.dl_en_idle", ifA.o_dl_en, 0);
                chk("bp.m_valid", ifA.o_m_valid, 1);
            end
        end
        chk("bp.accepted", acc, 8);
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            ifA.i_s_valid = 0; ifA.i_m_ready = 1;
            @(negedge clk);
            chk($sformatf("drain[%0d].m_valid", t), ifA.o_m_valid, (t < 8));
            if (t < 8) chk($sformatf("drain[%0d].m_data", t), ifA.o_m_data, 8'h40 + t);
            if (t == 0) chk("drain.s_ready_first", ifA.o_s_ready, 0);
            if (t == 1) chk("drain.s_ready_after", ifA.o_s_ready, 1);
        end

        // Flush with 3 items in the line and 2 in the FIFO, then 0x3C alone
        for (int t = 0; t < 15; t++) begin
            @(posedge clk); #1;
            ifA.i_s_valid = (t <= 4) || (t == 8);
            sdA = (t == 8) ? 8'h3C : 8'(8'h10 + t);
            ifA.i_m_ready = (t >= 7); flA = (t == 6);
            @(negedge clk);
            if (t == 6) begin
                chk("flush.s_ready", ifA.o_s_ready, 0);
                chk("flush.m_valid", ifA.o_m_valid, 0);
                chk("flush.dl_en", ifA.o_dl_en, 0);
            end
            if (t == 7) chk("flush.s_ready_after", ifA.o_s_ready, 1);
            if (t >= 7) chk($sformatf("flush[%0d].m_valid", t), ifA.o_m_valid, (t == 13));
            if (t == 13) chk("flush.m_data", ifA.o_m_data, 8'h3C);
        end
        flA = 0;

        // Async reset mid-stream
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            ifA.i_s_valid = 1; sdA = 8'(8'h60 + t); ifA.i_m_ready = 0;
        end
        @(negedge clk);
        chk("prerst.m_valid", ifA.o_m_valid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0; ifA.i_s_valid = 0;
        #1;
        chk("arst.s_ready", ifA.o_s_ready, 1);
        chk("arst.dl_en", ifA.o_dl_en, 0);
        chk("arst.m_valid", ifA.o_m_valid, 0);
        chk("arst.m_data", ifA.o_m_data, 0);
        @(negedge clk); rst_n = 1'b1;
        run_table("post_rst");

        // DUT B single item: latency 2
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            ifB.i_s_valid = (t == 0); sdB = 8'h5A; ifB.i_m_ready = 1;
            @(negedge clk);
            chk($sformatf("b_single[%0d].m_valid", t), ifB.o_m_valid, (t == 2));
            chk($sformatf("b_single[%0d].dl_en", t), ifB.o_dl_en, (t <= 1));
            if (t == 2) chk("b_single.m_data", ifB.o_m_data, 8'h5A);
        end

        // DUT B alternating i_m_ready: no loss, order kept
        nsent = 0; ngot = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            ifB.i_s_valid = (nsent < 12); sdB = 8'(8'h80 + nsent);
            ifB.i_m_ready = (t % 2 == 1);
            @(negedge clk);
            if (ifB.i_s_valid && ifB.o_s_ready) begin
                q.push_back(sdB);
                nsent++;
            end
            if (ifB.o_m_valid && ifB.i_m_ready) begin
                if (q.size() == 0) chk("alt.extra_item", q.size(), 1);
                else chk($sformatf("alt[%0d].m_data", ngot), ifB.o_m_data, q.pop_front());
                ngot++;
            end
        end
        chk("alt.sent", nsent, 12);
        chk("alt.received", ngot, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
